// File: rtl/hbm_tg_pkg.sv
// ============================================================================
//  Module   : hbm_tg_pkg
//  Brief    : Shared types, default sizes and state encoding for hbm_traffic_gen
//  Revision : 1.0
// ============================================================================
`default_nettype none

package hbm_tg_pkg;

    localparam int unsigned TG_NUM_CH = 16;
    localparam int unsigned TG_DATA_W = 256;
    localparam int unsigned TG_ADDR_W = 34;
    localparam int unsigned TG_CNT_W  = 16;

    typedef logic [TG_DATA_W-1:0] tg_data_t;
    typedef logic [TG_ADDR_W-1:0] tg_addr_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR     = 3'd1,
        ST_WGAP   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_RD     = 3'd4,
        ST_RGAP   = 3'd5,
        ST_DONE   = 3'd6
    } tg_state_e;

    // Where the run goes once the write phase has finished (or was skipped).
    function automatic tg_state_e post_write_state(input logic rd_zero, input logic settle_zero);
        if (rd_zero)     return ST_DONE;
        if (settle_zero) return ST_RD;
        return ST_SETTLE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hbm_tg_addr_gen.sv
// ============================================================================
//  Module   : hbm_tg_addr_gen
//  Brief    : Per-channel address and beat data from the current beat index
//  Revision : 1.0
// ============================================================================
`default_nettype none

module hbm_tg_addr_gen #(
    parameter int unsigned NUM_CH     = 16,
    parameter int unsigned DATA_W     = 256,
    parameter int unsigned ADDR_W     = 34,
    parameter logic [63:0] CH_STRIDE  = 64'h0_2000_0000,
    parameter int unsigned BEAT_BYTES = 32,
    parameter int unsigned CNT_W      = 16
) (
    input  logic [CNT_W-1:0]              beat,
    input  logic [DATA_W-1:0]             seed,
    output logic [NUM_CH-1:0][ADDR_W-1:0] addr,
    output logic [DATA_W-1:0]             data
);

    logic [63:0] w_beat_off;

    assign w_beat_off = 64'(beat) * 64'(BEAT_BYTES);
    assign data       = seed + DATA_W'(beat);

    // Addresses wrap naturally by truncation to ADDR_W.
    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            localparam logic [63:0] c_ch_base = 64'(i) * CH_STRIDE;
            assign addr[i] = ADDR_W'(c_ch_base + w_beat_off);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/hbm_traffic_gen.sv
// ============================================================================
//  Module   : hbm_traffic_gen
//  Brief    : Lock-step multi-channel HBM write/settle/read stimulus engine.
//             Optional read checking and deferred done under `TG_RDCHK_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module hbm_traffic_gen
    import hbm_tg_pkg::*;
#(
    parameter int unsigned NUM_CH     = TG_NUM_CH,
    parameter int unsigned DATA_W     = TG_DATA_W,
    parameter int unsigned ADDR_W     = TG_ADDR_W,
    parameter logic [63:0] CH_STRIDE  = 64'h0_2000_0000,
    parameter int unsigned BEAT_BYTES = 32,
    parameter int unsigned CNT_W      = TG_CNT_W
) (
    input  logic                          AXI_ACLK,
    input  logic                          AXI_ARESET,
    input  logic                          start,
    input  logic                          abort,
    input  logic [CNT_W-1:0]              num_wr_beats,
    input  logic [CNT_W-1:0]              num_rd_beats,
    input  logic [7:0]                    gap_cycles,
    input  logic [CNT_W-1:0]              settle_cycles,
    input  logic [DATA_W-1:0]             data_seed,
`ifdef TG_RDCHK_EN
    input  logic [NUM_CH-1:0]             read_valid,
    input  logic [NUM_CH-1:0][DATA_W-1:0] read_data,
    output logic [CNT_W-1:0]              err_count,
`endif
    output logic [NUM_CH-1:0]             write_enable,
    output logic [NUM_CH-1:0][DATA_W-1:0] write_data,
    output logic [NUM_CH-1:0][ADDR_W-1:0] write_address,
    output logic [NUM_CH-1:0]             read_enable,
    output logic [NUM_CH-1:0][ADDR_W-1:0] read_address,
    output logic                          busy,
    output logic                          done
);

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    tg_state_e                     state_q, state_d;
    logic [CNT_W-1:0]              beat_q, beat_d;
    logic [CNT_W-1:0]              settle_cnt_q, settle_cnt_d;
    logic [7:0]                    gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0]              num_wr_q, num_wr_d;
    logic [CNT_W-1:0]              num_rd_q, num_rd_d;
    logic [CNT_W-1:0]              settle_q, settle_d;
    logic [7:0]                    gap_q, gap_d;
    logic [DATA_W-1:0]             seed_q, seed_d;

    logic [NUM_CH-1:0]             we_q, we_d;
    logic [NUM_CH-1:0]             re_q, re_d;
    logic [NUM_CH-1:0][DATA_W-1:0] wdata_q, wdata_d;
    logic [NUM_CH-1:0][ADDR_W-1:0] waddr_q, waddr_d;
    logic [NUM_CH-1:0][ADDR_W-1:0] raddr_q, raddr_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;

    logic [NUM_CH-1:0][ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0]             w_data;
    logic                          w_accept;
    logic                          w_wr_last;
    logic                          w_rd_last;
    logic                          w_gap_done;
    logic                          w_rd_resp_done;

    hbm_tg_addr_gen #(
        .NUM_CH     (NUM_CH),
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .CH_STRIDE  (CH_STRIDE),
        .BEAT_BYTES (BEAT_BYTES),
        .CNT_W      (CNT_W)
    ) u_addr_gen (
        .beat (beat_q),
        .seed (seed_q),
        .addr (w_addr),
        .data (w_data)
    );

    assign w_accept   = (state_q == ST_IDLE) && start && !abort;
    assign w_wr_last  = (beat_q + c_cnt_one) == num_wr_q;
    assign w_rd_last  = (beat_q + c_cnt_one) == num_rd_q;
    assign w_gap_done = (gap_q == 8'd0) || (gap_cnt_q == (gap_q - 8'd1));

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        settle_cnt_d = settle_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        num_wr_d     = num_wr_q;
        num_rd_d     = num_rd_q;
        settle_d     = settle_q;
        gap_d        = gap_q;
        seed_d       = seed_q;

        unique case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    num_wr_d     = num_wr_beats;
                    num_rd_d     = num_rd_beats;
                    settle_d     = settle_cycles;
                    gap_d        = gap_cycles;
                    seed_d       = data_seed;
                    beat_d       = '0;
                    gap_cnt_d    = '0;
                    settle_cnt_d = '0;
                    state_d      = (num_wr_beats != '0) ? ST_WR :
                                   post_write_state(num_rd_beats == '0, settle_cycles == '0);
                end
            end
            ST_WR: begin
                beat_d    = beat_q + c_cnt_one;
                gap_cnt_d = '0;
                if (gap_q != 8'd0) begin
                    state_d = ST_WGAP;
                end else if (w_wr_last) begin
                    beat_d  = '0;
                    state_d = post_write_state(num_rd_q == '0, settle_q == '0);
                end
            end
            ST_WGAP: begin
                // beat_q already points past the beat just written here.
                if (w_gap_done) begin
                    if (beat_q == num_wr_q) begin
                        beat_d  = '0;
                        state_d = post_write_state(num_rd_q == '0, settle_q == '0);
                    end else begin
                        state_d = ST_WR;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == (settle_q - c_cnt_one)) begin
                    state_d = ST_RD;
                end else begin
                    settle_cnt_d = settle_cnt_q + c_cnt_one;
                end
            end
            ST_RD: begin
                beat_d    = beat_q + c_cnt_one;
                gap_cnt_d = '0;
                if (gap_q != 8'd0) begin
                    state_d = ST_RGAP;
                end else if (w_rd_last) begin
                    state_d = w_rd_resp_done ? ST_DONE : ST_RGAP;
                end
            end
            ST_RGAP: begin
                // Also the holding state while read responses are outstanding.
                if (w_gap_done) begin
                    if (beat_q != num_rd_q) begin
                        state_d = ST_RD;
                    end else if (w_rd_resp_done) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        we_d    = '0;
        re_d    = '0;
        done_d  = 1'b0;
        busy_d  = 1'b0;
        wdata_d = wdata_q;
        waddr_d = waddr_q;
        raddr_d = raddr_q;
        if (!abort) begin
            busy_d = (state_q != ST_IDLE);
            done_d = (state_q == ST_DONE);
            if (state_q == ST_WR) begin
                we_d    = '1;
                wdata_d = {NUM_CH{w_data}};
                waddr_d = w_addr;
            end
            if (state_q == ST_RD) begin
                re_d    = '1;
                raddr_d = w_addr;
            end
        end
    end

    always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
        if (AXI_ARESET) begin
            state_q      <= ST_IDLE;
            beat_q       <= '0;
            settle_cnt_q <= '0;
            gap_cnt_q    <= '0;
            num_wr_q     <= '0;
            num_rd_q     <= '0;
            settle_q     <= '0;
            gap_q        <= '0;
            seed_q       <= '0;
            we_q         <= '0;
            re_q         <= '0;
            wdata_q      <= '0;
            waddr_q      <= '0;
            raddr_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            settle_cnt_q <= settle_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            num_wr_q     <= num_wr_d;
            num_rd_q     <= num_rd_d;
            settle_q     <= settle_d;
            gap_q        <= gap_d;
            seed_q       <= seed_d;
            we_q         <= we_d;
            re_q         <= re_d;
            wdata_q      <= wdata_d;
            waddr_q      <= waddr_d;
            raddr_q      <= raddr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

`ifdef TG_RDCHK_EN
    logic [NUM_CH-1:0][CNT_W-1:0] resp_cnt_q, resp_cnt_d;
    logic [CNT_W-1:0]             err_q, err_d;
    logic [CNT_W:0]               w_mis_cnt;
    logic [CNT_W:0]               w_err_sum;

    always_comb begin
        resp_cnt_d     = resp_cnt_q;
        w_rd_resp_done = 1'b1;
        w_mis_cnt      = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (resp_cnt_q[ch] != num_rd_q) begin
                w_rd_resp_done = 1'b0;
            end
            if (read_valid[ch]) begin
                resp_cnt_d[ch] = resp_cnt_q[ch] + c_cnt_one;
                if (read_data[ch] != (seed_q + DATA_W'(resp_cnt_q[ch]))) begin
                    w_mis_cnt = w_mis_cnt + (CNT_W+1)'(1);
                end
            end
        end
        w_err_sum = {1'b0, err_q} + w_mis_cnt;
        err_d     = w_err_sum[CNT_W] ? '1 : w_err_sum[CNT_W-1:0];
        if (w_accept) begin
            resp_cnt_d = '0;
            err_d      = '0;
        end
    end

    always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
        if (AXI_ARESET) begin
            resp_cnt_q <= '0;
            err_q      <= '0;
        end else begin
            resp_cnt_q <= resp_cnt_d;
            err_q      <= err_d;
        end
    end

    assign err_count = err_q;
`else
    assign w_rd_resp_done = 1'b1;
`endif

    assign write_enable  = we_q;
    assign write_data    = wdata_q;
    assign write_address = waddr_q;
    assign read_enable   = re_q;
    assign read_address  = raddr_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

`default_nettype wire

// File: tb/tb_hbm_traffic_gen.sv
// ============================================================================
//  Module   : tb_hbm_traffic_gen
//  Brief    : Directed scoreboard bench for hbm_traffic_gen (NUM_CH=16, defaults)
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hbm_traffic_gen;
    import hbm_tg_pkg::*;

    localparam int NUM_CH = 16;
    localparam int DATA_W = 256;
    localparam int ADDR_W = 34;
    localparam int CNT_W  = 16;

    typedef struct {
        tg_addr_t a0;
        tg_addr_t a5;
        tg_addr_t a15;
        tg_data_t d;
    } exp_t;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic                          start = 1'b0;
    logic                          abort = 1'b0;
    logic [CNT_W-1:0]              num_wr_beats = '0;
    logic [CNT_W-1:0]              num_rd_beats = '0;
    logic [7:0]                    gap_cycles = '0;
    logic [CNT_W-1:0]              settle_cycles = '0;
    logic [DATA_W-1:0]             data_seed = '0;
    logic [NUM_CH-1:0]             write_enable;
    logic [NUM_CH-1:0][DATA_W-1:0] write_data;
    logic [NUM_CH-1:0][ADDR_W-1:0] write_address;
    logic [NUM_CH-1:0]             read_enable;
    logic [NUM_CH-1:0][ADDR_W-1:0] read_address;
    logic                          busy;
    logic                          done;

    exp_t         wr_q[$];
    exp_t         rd_q[$];
    int           we_cyc[$];
    int           re_cyc[$];
    int           done_cyc[$];
    int           vectors = 0;
    int           miscompares = 0;
    int           cyc = 0;
    int           start_cyc = 0;
    logic [255:0] last_seed = '0;

`ifdef TG_RDCHK_EN
    logic [NUM_CH-1:0]             read_valid = '0;
    logic [NUM_CH-1:0][DATA_W-1:0] read_data = '0;
    logic [CNT_W-1:0]              err_count;
    int                            echo_idx = 0;
    int                            last_valid_cyc = 0;
    logic                          corrupt = 1'b0;
`endif

    hbm_traffic_gen dut (
        .AXI_ACLK      (clk),
        .AXI_ARESET    (rst),
        .start         (start),
        .abort         (abort),
        .num_wr_beats  (num_wr_beats),
        .num_rd_beats  (num_rd_beats),
        .gap_cycles    (gap_cycles),
        .settle_cycles (settle_cycles),
        .data_seed     (data_seed),
`ifdef TG_RDCHK_EN
        .read_valid    (read_valid),
        .read_data     (read_data),
        .err_count     (err_count),
`endif
        .write_enable  (write_enable),
        .write_data    (write_data),
        .write_address (write_address),
        .read_enable   (read_enable),
        .read_address  (read_address),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic tg_addr_t exp_addr(input int ch, input int k);
        logic [63:0] v;
        v = 64'(ch) * 64'h2000_0000 + 64'(k) * 64'd32;
        return v[ADDR_W-1:0];
    endfunction

    // Scoreboard consumer: every strobe must match the oldest pending beat.
    always @(negedge clk) begin
        exp_t e;
        if (|write_enable) begin
            we_cyc.push_back(cyc);
            chk("we_all_ch", 256'(write_enable), 256'({NUM_CH{1'b1}}));
            chk("we_expected", 256'(wr_q.size() > 0), 256'd1);
            if (wr_q.size() > 0) begin
                e = wr_q.pop_front();
                chk("waddr_ch0", 256'(write_address[0]), 256'(e.a0));
                chk("waddr_ch5", 256'(write_address[5]), 256'(e.a5));
                chk("waddr_ch15", 256'(write_address[15]), 256'(e.a15));
                chk("wdata_ch0", write_data[0], e.d);
                chk("wdata_ch15", write_data[15], e.d);
            end
        end
        if (|read_enable) begin
            re_cyc.push_back(cyc);
            chk("re_all_ch", 256'(read_enable), 256'({NUM_CH{1'b1}}));
            chk("re_expected", 256'(rd_q.size() > 0), 256'd1);
            if (rd_q.size() > 0) begin
                e = rd_q.pop_front();
                chk("raddr_ch0", 256'(read_address[0]), 256'(e.a0));
                chk("raddr_ch5", 256'(read_address[5]), 256'(e.a5));
                chk("raddr_ch15", 256'(read_address[15]), 256'(e.a15));
            end
        end
        if (done) done_cyc.push_back(cyc);
    end

`ifdef TG_RDCHK_EN
    // Memory echo model: one response per channel per read strobe.
    always @(negedge clk) begin
        read_valid <= read_enable;
        if (start) echo_idx <= 0;
        else if (read_enable[0]) echo_idx <= echo_idx + 1;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (corrupt && ch == 7 && echo_idx == 0) read_data[ch] <= ~last_seed;
            else read_data[ch] <= last_seed + 256'(echo_idx);
        end
        if (|read_valid) last_valid_cyc <= cyc;
    end
`endif

    task automatic launch(input int wr, input int rd, input int gap, input int settle,
                          input logic [255:0] seed);
        exp_t e;
        @(posedge clk); #1;
        num_wr_beats  = CNT_W'(wr);
        num_rd_beats  = CNT_W'(rd);
        gap_cycles    = 8'(gap);
        settle_cycles = CNT_W'(settle);
        data_seed     = seed;
        last_seed     = seed;
        for (int k = 0; k < wr; k++) begin
            e.a0 = exp_addr(0, k); e.a5 = exp_addr(5, k); e.a15 = exp_addr(15, k);
            e.d  = seed + 256'(k);
            wr_q.push_back(e);
        end
        for (int k = 0; k < rd; k++) begin
            e.a0 = exp_addr(0, k); e.a5 = exp_addr(5, k); e.a15 = exp_addr(15, k);
            e.d  = seed + 256'(k);
            rd_q.push_back(e);
        end
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start         = 1'b0;
        num_wr_beats  = '1;
        num_rd_beats  = '1;
        gap_cycles    = 8'd7;
        settle_cycles = '1;
        data_seed     = '1;
    endtask

    task automatic wait_done(input int limit, input string tag);
        int n;
        int g;
        n = done_cyc.size();
        g = 0;
        while (done_cyc.size() == n && g < limit) begin
            @(posedge clk);
            g++;
        end
        chk({tag, "_done_seen"}, 256'(done_cyc.size() > n), 256'd1);
    endtask

    task automatic run_t1(input string tag);
        int w0;
        w0 = we_cyc.size();
        launch(2, 0, 2, 0, 256'h4920);
        wait_done(100, tag);
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_we_count"}, 256'(we_cyc.size() - w0), 256'd2);
        if (we_cyc.size() >= w0 + 2) begin
            chk({tag, "_we_spacing"}, 256'(we_cyc[w0+1] - we_cyc[w0]), 256'd3);
            chk({tag, "_done_lat"}, 256'(done_cyc[$] - we_cyc[w0+1]), 256'd3);
        end
        chk({tag, "_busy_idle"}, 256'(busy), 256'd0);
        chk({tag, "_waddr5_hold"}, 256'(write_address[5]), 256'(34'h0_A000_0020));
        chk({tag, "_wdata5_hold"}, write_data[5], 256'h4921);
        chk({tag, "_wr_q_empty"}, 256'(wr_q.size()), 256'd0);
    endtask

    initial begin
        int w0;
        int r0;
        int d0;
        int g;
        logic consec;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", 256'(write_enable), 256'd0);
        chk("rst_re", 256'(read_enable), 256'd0);
        chk("rst_busy", 256'(busy), 256'd0);
        chk("rst_done", 256'(done), 256'd0);
        chk("rst_waddr15", 256'(write_address[15]), 256'd0);
        chk("rst_wdata0", write_data[0], 256'd0);
        rst = 1'b0;

        // T1: two writes, gap 2, no reads
        run_t1("T1");

        // T2: back-to-back writes, long settle, one read
        w0 = we_cyc.size();
        r0 = re_cyc.size();
        launch(16, 1, 0, 17, 256'hA5A5_0000);
        wait_done(200, "T2");
        chk("T2_we_count", 256'(we_cyc.size() - w0), 256'd16);
        chk("T2_re_count", 256'(re_cyc.size() - r0), 256'd1);
        if (we_cyc.size() >= w0 + 16 && re_cyc.size() > r0) begin
            consec = 1'b1;
            for (int k = 1; k < 16; k++) if (we_cyc[w0+k] - we_cyc[w0+k-1] != 1) consec = 1'b0;
            chk("T2_we_consecutive", 256'(consec), 256'd1);
            chk("T2_settle_lat", 256'(re_cyc[r0] - we_cyc[w0+15]), 256'd18);
`ifdef TG_RDCHK_EN
            chk("T2_done_lat", 256'(done_cyc[$] - re_cyc[r0]), 256'd3);
`else
            chk("T2_done_lat", 256'(done_cyc[$] - re_cyc[r0]), 256'd1);
`endif
        end
        chk("T2_raddr15", 256'(read_address[15]), 256'(34'h1_E000_0000));
        chk("T2_rd_q_empty", 256'(rd_q.size()), 256'd0);

        // T3: empty run
        w0 = we_cyc.size();
        r0 = re_cyc.size();
        launch(0, 0, 5, 5, 256'h1);
        wait_done(20, "T3");
        chk("T3_done_lat", 256'(done_cyc[$] - start_cyc), 256'd2);
        chk("T3_no_we", 256'(we_cyc.size() - w0), 256'd0);
        chk("T3_no_re", 256'(re_cyc.size() - r0), 256'd0);

        // T4: abort inside the gap after beat index 3
        w0 = we_cyc.size();
        launch(6, 2, 3, 4, 256'hC0DE);
        g = 0;
        while (we_cyc.size() < w0 + 4 && g < 200) begin
            @(posedge clk);
            g++;
        end
        chk("T4_reached_beat3", 256'(we_cyc.size() >= w0 + 4), 256'd1);
        #1;
        abort = 1'b1;
        wr_q.delete();
        rd_q.delete();
        d0 = done_cyc.size();
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("T4_busy_drop", 256'(busy), 256'd0);
        repeat (30) @(posedge clk);
        chk("T4_no_more_we", 256'(we_cyc.size() - w0), 256'd4);
        chk("T4_no_done", 256'(done_cyc.size() - d0), 256'd0);
        launch(1, 1, 0, 0, 256'h77);
        wait_done(50, "T4_restart");

        // T5: asynchronous reset during the read phase, then T1 again
        launch(2, 4, 2, 3, 256'h4920);
        g = 0;
        while (!read_enable[0] && g < 300) begin
            @(negedge clk);
            g++;
        end
        chk("T5_in_read", 256'(read_enable[0]), 256'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("T5_re_async_drop", 256'(read_enable), 256'd0);
        chk("T5_busy_async_drop", 256'(busy), 256'd0);
        wr_q.delete();
        rd_q.delete();
        d0 = done_cyc.size();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("T5_no_done", 256'(done_cyc.size() - d0), 256'd0);
        run_t1("T5_rerun");

`ifdef TG_RDCHK_EN
        // T6: read check with channel 7 beat 0 corrupted
        corrupt = 1'b1;
        launch(0, 3, 0, 0, 256'hBEEF);
        wait_done(100, "T6");
        chk("T6_err_count", 256'(err_count), 256'd1);
        chk("T6_done_after_resp", 256'(done_cyc[$] > last_valid_cyc), 256'd1);
        corrupt = 1'b0;
`endif

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
